uart_tx_arbiter: RTL and testbench

- Shares one UART byte transmitter between NREQ message sources, such as several string generators each emitting a fixed greeting.
- Grants the transmitter round-robin per message and feeds it one byte at a time over a start/busy handshake.
- Keeps message bytes contiguous and enforces a burst cap and an inter-message idle gap.
- Sits between the message generators and the single transmitter driving the serial line.

---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter between NREQ message sources, one message per grant.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
module uart_tx_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned IDLE_GAP  = 2
) (
    input  logic              CP,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   grant,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO,
        GAP
    } state_t;

    state_t        state;
    logic [PW-1:0] gidx;
    logic          msg_last;
    logic [7:0]    burst;
    logic [3:0]    gap_cnt;

`ifndef UART_ARB_FIXED_PRIO_EN
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] next_ptr;
`endif

    logic [7:0]    req_bytes [NREQ];
    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] scan_idx;
    logic          release_now;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_bytes[i] = req_data[8*i +: 8];
        end
    end

    // Scan starts at rr_ptr (or index 0 for fixed priority); first requester found wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            scan_idx = PW'(i);
`else
            scan_idx = PW'((32'(rr_ptr) + i) % NREQ);
`endif
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

`ifndef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        next_ptr = PW'((32'(gidx) + 32'd1) % NREQ);
    end
`endif

    // Release points are shared by SEND (owner dropped req) and WAIT_LO (byte finished).
    always_comb begin
        release_now = 1'b0;
        if (state == SEND && !req[gidx]) begin
            release_now = 1'b1;
        end else if (state == WAIT_LO && !tx_busy &&
                     (msg_last || burst == 8'(MAX_BURST) || !req[gidx])) begin
            release_now = 1'b1;
        end
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            state    <= IDLE;
            grant    <= '0;
            req_ack  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            gidx     <= '0;
            msg_last <= 1'b0;
            burst    <= '0;
            gap_cnt  <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            req_ack  <= '0;
            tx_start <= 1'b0;
            if (release_now) begin
                grant   <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
                rr_ptr  <= next_ptr;
`endif
                gap_cnt <= 4'(IDLE_GAP);
                state   <= (IDLE_GAP == 0) ? IDLE : GAP;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (pick_found) begin
                            grant <= onehot(pick_idx);
                            gidx  <= pick_idx;
                            burst <= '0;
                            state <= SEND;
                        end
                    end
                    SEND: begin
                        if (!tx_busy) begin
                            tx_start <= 1'b1;
                            req_ack  <= onehot(gidx);
                            tx_data  <= req_bytes[gidx];
                            msg_last <= req_last[gidx];
                            if (burst != 8'(MAX_BURST)) begin
                                burst <= burst + 8'd1;
                            end
                            state <= WAIT_HI;
                        end
                    end
                    WAIT_HI: begin
                        if (tx_busy) begin
                            state <= WAIT_LO;
                        end
                    end
                    WAIT_LO: begin
                        if (!tx_busy) begin
                            state <= SEND;
                        end
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt - 4'd1;
                        if (gap_cnt <= 4'd1) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a 10-cycle transmitter model,
// and a log of every tx_start compared against hand-computed tables.
module tb_uart_tx_arbiter;
    logic        CP = 1'b0;
    logic        RST;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;

    uart_tx_arbiter #(.NREQ(4), .MAX_BURST(16), .IDLE_GAP(2)) dut (
        .CP       (CP),
        .RST      (RST),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    always #5 CP = ~CP;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    always @(posedge CP) cyc <= cyc + 1;

    // Requester model: per-source byte FIFO, popped on req_ack.
    logic [8:0]  mem [4][32];
    int unsigned head [4] = '{default: 0};
    int unsigned tail [4] = '{default: 0};
    int unsigned ack_cnt [4] = '{default: 0};
    logic [3:0]  en;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i]             = en[i] && (head[i] != tail[i]);
            req_data[8*i +: 8] = mem[i][head[i][4:0]][7:0];
            req_last[i]        = mem[i][head[i][4:0]][8];
        end
    end

    always @(posedge CP) begin
        for (int i = 0; i < 4; i++) begin
            if (req_ack[i] === 1'b1) begin
                head[i]    <= head[i] + 1;
                ack_cnt[i] <= ack_cnt[i] + 1;
            end
        end
    end

    // Transmitter model: busy for 10 cycles from the cycle after tx_start.
    int unsigned bcnt = 0;
    logic        bforce;
    always @(posedge CP) begin
        if (RST) bcnt <= 0;
        else if (tx_start) bcnt <= 10;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0) || bforce;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [3:0]  log_g [$];
    logic [7:0]  log_d [$];
    logic [3:0]  log_a [$];
    logic [3:0]  gl [$];
    int unsigned gc [$];
    logic [3:0]  prev_grant = '0;

    always @(negedge CP) begin
        if (RST === 1'b0) begin
            check("invariant",
                  32'((tx_start ? ($onehot(req_ack) && req_ack == grant) : (req_ack == 4'b0))
                      && $onehot0(grant)), 32'd1);
            if (tx_start) begin
                log_g.push_back(grant);
                log_d.push_back(tx_data);
                log_a.push_back(req_ack);
            end
            if (grant != prev_grant) begin
                gl.push_back(grant);
                gc.push_back(cyc);
                prev_grant = grant;
            end
        end
    end

    typedef struct {
        int unsigned src;
        logic [7:0]  data;
        logic        last;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t vecs [$];

    task automatic add_vec(input int unsigned s, input logic [7:0] d, input logic l,
                           input logic [3:0] eg, input logic [7:0] ed);
        vec_t v;
        v.src = s; v.data = d; v.last = l; v.exp_grant = eg; v.exp_data = ed;
        vecs.push_back(v);
    endtask

    task automatic push(input int unsigned r, input logic [7:0] d, input logic l);
        mem[r][tail[r][4:0]] = {l, d};
        tail[r] = tail[r] + 1;
    endtask

    task automatic clear_log();
        log_g.delete(); log_d.delete(); log_a.delete();
        gl.delete(); gc.delete();
    endtask

    task automatic apply_vecs();
        clear_log();
        foreach (vecs[i]) push(vecs[i].src, vecs[i].data, vecs[i].last);
    endtask

    task automatic wait_quiet(input int unsigned budget);
        int unsigned n = 0;
        int unsigned quiet = 0;
        while (quiet < 6 && n < budget) begin
            @(negedge CP);
            n++;
            if (grant == 4'b0 && !tx_busy && req == 4'b0) quiet++;
            else quiet = 0;
        end
        check("quiet_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_grant(input logic [3:0] g, input int unsigned budget);
        int unsigned n = 0;
        while (grant !== g && n < budget) begin
            @(negedge CP);
            n++;
        end
        check("grant_timeout", 32'(grant), 32'(g));
    endtask

    task automatic wait_ack(input int unsigned r, input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (ack_cnt[r] < target && n < budget) begin
            @(negedge CP);
            n++;
        end
        check("ack_timeout", ack_cnt[r], target);
    endtask

    task automatic check_vecs(input string name, input int unsigned budget);
        wait_quiet(budget);
        check({name, "_count"}, log_g.size(), vecs.size());
        foreach (vecs[i]) begin
            if (i < log_g.size()) begin
                check({name, "_grant"}, 32'(log_g[i]), 32'(vecs[i].exp_grant));
                check({name, "_data"},  32'(log_d[i]), 32'(vecs[i].exp_data));
                check({name, "_ack"},   32'(log_a[i]), 32'(vecs[i].exp_grant));
            end
        end
    endtask

    initial begin
        int unsigned base;
        RST = 1'b1;
        en = 4'b1111;
        bforce = 1'b0;

        // Reset held with all four requesting, then one message each in index order.
        vecs.delete();
        add_vec(0, 8'hA0, 1'b1, 4'b0001, 8'hA0);
        add_vec(1, 8'hA1, 1'b1, 4'b0010, 8'hA1);
        add_vec(2, 8'hA2, 1'b1, 4'b0100, 8'hA2);
        add_vec(3, 8'hA3, 1'b1, 4'b1000, 8'hA3);
        apply_vecs();
        for (int c = 0; c < 3; c++) begin
            @(negedge CP);
            check("rst_grant",    32'(grant),    32'd0);
            check("rst_tx_start", 32'(tx_start), 32'd0);
            check("rst_tx_data",  32'(tx_data),  32'd0);
            check("rst_req_ack",  32'(req_ack),  32'd0);
        end
        RST = 1'b0;
        @(negedge CP);
        check("first_grant", 32'(grant), 32'b0001);
        check_vecs("rst_msgs", 500);

        // Two 1-byte messages each on req0 and req2.
        vecs.delete();
`ifdef UART_ARB_FIXED_PRIO_EN
        add_vec(0, 8'hB0, 1'b1, 4'b0001, 8'hB0);
        add_vec(0, 8'hB1, 1'b1, 4'b0001, 8'hB1);
        add_vec(2, 8'hC0, 1'b1, 4'b0100, 8'hC0);
        add_vec(2, 8'hC1, 1'b1, 4'b0100, 8'hC1);
`else
        add_vec(0, 8'hB0, 1'b1, 4'b0001, 8'hB0);
        add_vec(2, 8'hC0, 1'b1, 4'b0100, 8'hC0);
        add_vec(0, 8'hB1, 1'b1, 4'b0001, 8'hB1);
        add_vec(2, 8'hC1, 1'b1, 4'b0100, 8'hC1);
`endif
        apply_vecs();
        check_vecs("rr", 500);

        // "Hi!" on req0 with a pending 1-byte message on req1; grant is 0 for IDLE_GAP+1 cycles.
        vecs.delete();
        add_vec(0, 8'h48, 1'b0, 4'b0001, 8'h48);
        add_vec(0, 8'h69, 1'b0, 4'b0001, 8'h69);
        add_vec(0, 8'h21, 1'b1, 4'b0001, 8'h21);
        add_vec(1, 8'h55, 1'b1, 4'b0010, 8'h55);
        apply_vecs();
        check_vecs("hi", 500);
        check("hi_gl_count", gl.size(), 4);
        if (gl.size() >= 3) begin
            check("hi_gl_0", 32'(gl[0]), 32'b0001);
            check("hi_gl_1", 32'(gl[1]), 32'b0000);
            check("hi_gl_2", 32'(gl[2]), 32'b0010);
            check("hi_gap_len", gc[2] - gc[1], 3);
        end

        // Burst cap: req1 streams 20 bytes, req2 arrives once req1 owns the transmitter.
        clear_log();
        vecs.delete();
        for (int i = 0; i < 20; i++) push(1, 8'(8'h10 + i), 1'b0);
        wait_grant(4'b0010, 50);
        push(2, 8'h77, 1'b1);
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 20; i++) add_vec(1, 8'(8'h10 + i), 1'b0, 4'b0010, 8'(8'h10 + i));
        add_vec(2, 8'h77, 1'b1, 4'b0100, 8'h77);
`else
        for (int i = 0; i < 16; i++) add_vec(1, 8'(8'h10 + i), 1'b0, 4'b0010, 8'(8'h10 + i));
        add_vec(2, 8'h77, 1'b1, 4'b0100, 8'h77);
        for (int i = 16; i < 20; i++) add_vec(1, 8'(8'h10 + i), 1'b0, 4'b0010, 8'(8'h10 + i));
`endif
        check_vecs("burst", 3000);

        // req3 drops req after its 2nd byte; next round starts from req0.
        clear_log();
        vecs.delete();
        push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b0);
        push(3, 8'h33, 1'b0);
        wait_ack(3, ack_cnt[3] + 2, 200);
        repeat (4) @(negedge CP);
        en[3] = 1'b0;
        add_vec(3, 8'h31, 1'b0, 4'b1000, 8'h31);
        add_vec(3, 8'h32, 1'b0, 4'b1000, 8'h32);
        check_vecs("drop", 500);

        clear_log();
        vecs.delete();
        en[3] = 1'b1;
        push(0, 8'h0A, 1'b1);
        add_vec(0, 8'h0A, 1'b1, 4'b0001, 8'h0A);
        add_vec(3, 8'h33, 1'b0, 4'b1000, 8'h33);
        check_vecs("after_drop", 500);

        // Transmitter busy on entry to SEND: tx_start waits, one ack only.
        clear_log();
        base = ack_cnt[2];
        @(negedge CP);
        bforce = 1'b1;
        push(2, 8'h5A, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge CP);
            if (c == 0) check("busy_grant", 32'(grant), 32'b0100);
            check("busy_held_no_start", 32'(tx_start), 32'd0);
        end
        bforce = 1'b0;
        @(negedge CP);
        check("busy_start",   32'(tx_start), 32'd1);
        check("busy_ack",     32'(req_ack),  32'b0100);
        check("busy_tx_data", 32'(tx_data),  32'h5A);
        wait_quiet(300);
        check("busy_ack_total", ack_cnt[2] - base, 1);
        check("busy_log_count", log_g.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
